// File: rtl/image_ram_reader_pkg.sv
// Shared types and constants for the image RAM reader: FSM states and
// pixel/word geometry.
package image_ram_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD     = 4;
    localparam int PIX_W              = 8;
    localparam int WORD_W             = BYTES_PER_WORD * PIX_W;
    localparam int BYTE_IDX_W         = 2;
    localparam int DEFAULT_NUM_PIXELS = 784;
    // Wide enough to count up to the largest legal image (4096 pixels).
    localparam int PIX_CNT_W          = 13;

endpackage

// File: rtl/image_word_unpacker.sv
// Holds one fetched RAM word and presents its bytes one at a time,
// little-endian, as the consumer accepts them.
module image_word_unpacker
    import image_ram_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_W-1:0]     word_in,
    output logic [PIX_W-1:0]      pix_data,
    output logic [BYTE_IDX_W-1:0] byte_idx
);

    logic [WORD_W-1:0]     word_reg;
    logic [BYTE_IDX_W-1:0] byte_idx_reg;
    logic [PIX_W-1:0]      word_bytes [BYTES_PER_WORD];

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[gi*PIX_W +: PIX_W];
        end
    endgenerate

    // A freshly loaded word always starts presenting from byte 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg     <= '0;
            byte_idx_reg <= '0;
        end else begin
            if (load) begin
                word_reg <= word_in;
            end
            if (clear || load) begin
                byte_idx_reg <= '0;
            end else if (advance) begin
                byte_idx_reg <= byte_idx_reg + BYTE_IDX_W'(1);
            end
        end
    end

    assign pix_data = word_bytes[byte_idx_reg];
    assign byte_idx = byte_idx_reg;

endmodule

// File: rtl/image_ram_reader.sv
// Streams one image out of a 32-bit word RAM as a valid/ready byte stream,
// one word fetch per four pixels.
module image_ram_reader
    import image_ram_reader_pkg::*;
#(
    parameter int BASE_ADDR  = 0,
    parameter int NUM_PIXELS = DEFAULT_NUM_PIXELS,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_clken,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata,
    output logic [7:0]        pix_data,
    input  logic              pix_ready,
    output logic              pix_valid,
    output logic              pix_last
);

    localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0]    BASE     = ADDR_W'(BASE_ADDR);

    state_t                  state_reg, state_next;
    logic [ADDR_W-1:0]       word_idx_reg, word_idx_next;
    logic [PIX_CNT_W-1:0]    pix_cnt_reg, pix_cnt_next;

    logic                    unpack_clear;
    logic                    unpack_load;
    logic                    unpack_advance;
    logic [PIX_W-1:0]        unpack_data;
    logic [BYTE_IDX_W-1:0]   byte_idx;
    logic                    handshake;
    logic                    at_last_pix;

    image_word_unpacker u_unpacker (
        .clk      (clk),
        .reset    (reset),
        .clear    (unpack_clear),
        .load     (unpack_load),
        .advance  (unpack_advance),
        .word_in  (ram_readdata),
        .pix_data (unpack_data),
        .byte_idx (byte_idx)
    );

    assign handshake   = (state_reg == EMIT) && pix_ready;
    assign at_last_pix = (pix_cnt_reg == LAST_PIX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            word_idx_reg <= '0;
            pix_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            word_idx_reg <= word_idx_next;
            pix_cnt_reg  <= pix_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        word_idx_next  = word_idx_reg;
        pix_cnt_next   = pix_cnt_reg;
        unpack_clear   = 1'b0;
        unpack_load    = 1'b0;
        unpack_advance = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = FETCH;
                    word_idx_next = '0;
                    pix_cnt_next  = '0;
                    unpack_clear  = 1'b1;
                end
            end
            FETCH: state_next = WAIT;
            WAIT: begin
                unpack_load = 1'b1;
                state_next  = EMIT;
            end
            EMIT: begin
                if (handshake) begin
                    unpack_advance = 1'b1;
                    pix_cnt_next   = pix_cnt_reg + PIX_CNT_W'(1);
                    // The pixel count ends a partial last word before byte 3.
                    if (at_last_pix) begin
                        state_next = DONE;
                    end else if (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
                        word_idx_next = word_idx_reg + ADDR_W'(1);
                        state_next    = FETCH;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are masked by reset so they read zero for the whole reset window.
    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        ram_address    = '0;
        ram_chipselect = 1'b0;
        ram_clken      = 1'b0;
        pix_valid      = 1'b0;
        pix_last       = 1'b0;
        pix_data       = '0;

        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    busy           = 1'b1;
                    ram_address    = BASE + word_idx_reg;
                    ram_chipselect = 1'b1;
                    ram_clken      = 1'b1;
                end
                WAIT: begin
                    busy      = 1'b1;
                    ram_clken = 1'b1;
                end
                EMIT: begin
                    busy      = 1'b1;
                    pix_valid = 1'b1;
                    pix_data  = unpack_data;
                    pix_last  = at_last_pix;
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

    assign ram_write      = 1'b0;
    assign ram_byteenable = 4'hF;
    assign ram_writedata  = 32'h0;

endmodule

// File: tb/tb_image_ram_reader.sv
// Directed bench for image_ram_reader: a default 784-pixel instance and a
// 6-pixel instance at base address 10, each fed by a small RAM model.
module tb_image_ram_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, s_start, pix_ready;
    bit   rand_ready = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Default instance signals
    logic        busy, done, ram_chipselect, ram_clken, ram_write, pix_valid, pix_last;
    logic [9:0]  ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata, ram_readdata;
    logic [7:0]  pix_data;

    // Small instance signals
    logic        s_busy, s_done, s_cs, s_clken, s_write, s_valid, s_last;
    logic [9:0]  s_address;
    logic [3:0]  s_be;
    logic [31:0] s_wdata, s_rdata;
    logic [7:0]  s_data;

    image_ram_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
        .ram_write(ram_write), .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
        .ram_readdata(ram_readdata), .pix_data(pix_data), .pix_ready(pix_ready),
        .pix_valid(pix_valid), .pix_last(pix_last)
    );

    image_ram_reader #(.BASE_ADDR(10), .NUM_PIXELS(6), .ADDR_W(10)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .busy(s_busy), .done(s_done),
        .ram_address(s_address), .ram_chipselect(s_cs), .ram_clken(s_clken),
        .ram_write(s_write), .ram_byteenable(s_be), .ram_writedata(s_wdata),
        .ram_readdata(s_rdata), .pix_data(s_data), .pix_ready(1'b1),
        .pix_valid(s_valid), .pix_last(s_last)
    );

    function automatic logic [31:0] mk_word(input int a);
        return {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
    endfunction

    // Pixel n of the default image lives in word n/4, byte n%4.
    function automatic logic [7:0] exp_pix(input int n);
        return 8'(n / 4 + n % 4);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_chipselect && ram_clken) ram_readdata <= mk_word(int'(ram_address));
    always @(posedge clk) if (s_cs && s_clken) s_rdata <= mk_word(int'(s_address));

    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitors: record handshakes, reads, done pulses and protocol errors.
    logic [7:0] q_pix[$], s_q_pix[$];
    int   q_addr[$], s_q_addr[$];
    int   last_cnt = 0, last_pos = -1, done_cnt = 0, stab_err = 0, prot_err = 0;
    int   s_last_cnt = 0, s_last_pos = -1, s_done_cnt = 0, s_prot_err = 0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic prev_last;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (prev_stall && (!pix_valid || pix_data !== prev_data || pix_last !== prev_last))
                stab_err++;
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            if (pix_valid && pix_ready) begin
                if (pix_last) begin
                    last_cnt++;
                    last_pos = q_pix.size();
                end
                q_pix.push_back(pix_data);
            end
            if (ram_chipselect && ram_clken) q_addr.push_back(int'(ram_address));
            if (done) done_cnt++;
            if (ram_write !== 1'b0 || ram_byteenable !== 4'hF || ram_writedata !== 32'h0 ||
                (ram_clken && (pix_valid || done || !busy)) || (ram_chipselect && !ram_clken))
                prot_err++;

            if (s_valid) begin
                if (s_last) begin
                    s_last_cnt++;
                    s_last_pos = s_q_pix.size();
                end
                s_q_pix.push_back(s_data);
            end
            if (s_cs && s_clken) s_q_addr.push_back(int'(s_address));
            if (s_done) s_done_cnt++;
            if (s_write !== 1'b0 || s_be !== 4'hF || s_wdata !== 32'h0 ||
                (s_clken && (s_valid || s_done || !s_busy)))
                s_prot_err++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_a(input int inject_at, output int t_start, output int t_first,
                         output int t_done, output bit ok);
        int  base;
        bit  injected;
        base = q_pix.size();
        injected = 1'b0;
        t_first = -1;
        t_done = -1;
        ok = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        t_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (start) start = 1'b0;
            if (pix_valid && t_first < 0) t_first = cyc;
            if (inject_at >= 0 && !injected && q_pix.size() - base >= inject_at) begin
                start = 1'b1;
                injected = 1'b1;
            end
            if (done) begin
                t_done = cyc;
                ok = 1'b1;
                if (inject_at >= 0) start = 1'b1;
                break;
            end
        end
        if (start) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; s_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({busy, done, pix_valid, pix_last, ram_chipselect, ram_clken} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                {busy, done, pix_valid, pix_last, ram_chipselect, ram_clken});
        end
        n_checks++;
        if (ram_address !== 10'd0 || pix_data !== 8'd0) begin
            n_fail++; $display("FAIL reset_data: addr %0d data %0d expected 0 0", ram_address, pix_data);
        end
        n_checks++;
        if ({s_busy, s_done, s_valid, s_last, s_cs, s_clken} !== 6'b0 || s_address !== 10'd0) begin
            n_fail++; $display("FAIL reset_small: ctrl %b addr %0d expected 0 0",
                {s_busy, s_done, s_valid, s_last, s_cs, s_clken}, s_address);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_busy: got %b expected 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_full_stream();
        int  bp, ba, bd, bl, ts, tf, td, errs;
        bit  ok;
        bp = q_pix.size(); ba = q_addr.size(); bd = done_cnt; bl = last_cnt;
        run_a(-1, ts, tf, td, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL full_timeout: got no done expected done"); end
        n_checks++;
        if (q_addr.size() - ba !== 196) begin
            n_fail++; $display("FAIL full_reads: got %0d expected 196", q_addr.size() - ba);
        end
        errs = 0;
        for (int i = 0; i < 196 && ba + i < q_addr.size(); i++) if (q_addr[ba + i] != i) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL full_addr_seq: got %0d bad expected 0", errs); end
        n_checks++;
        if (q_pix.size() - bp !== 784) begin
            n_fail++; $display("FAIL full_pix_count: got %0d expected 784", q_pix.size() - bp);
        end
        errs = 0;
        for (int i = 0; i < 784 && bp + i < q_pix.size(); i++) if (q_pix[bp + i] !== exp_pix(i)) errs++;
        n_checks++;
        if (errs !== 0) begin n_fail++; $display("FAIL full_pix_values: got %0d bad expected 0", errs); end
        n_checks++;
        if (last_cnt - bl !== 1 || last_pos !== bp + 783) begin
            n_fail++; $display("FAIL full_last: got count %0d pos %0d expected 1 %0d",
                last_cnt - bl, last_pos - bp, 783);
        end
        n_checks++;
        if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL full_done: got %0d expected 1", done_cnt - bd); end
        n_checks++;
        if (tf - ts !== 3) begin n_fail++; $display("FAIL full_latency: got %0d expected 3", tf - ts); end
        // 784 pixels plus 195 two-cycle word bubbles, then the done cycle.
        n_checks++;
        if (td - ts !== 1177) begin n_fail++; $display("FAIL full_done_time: got %0d expected 1177", td - ts); end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL full_after: busy %b done %b expected 0 0", busy, done);
        end
        $display("test_full_stream: %0d pixels, %0d reads", q_pix.size() - bp, q_addr.size() - ba);
    endtask

    task automatic test_stall();
        int  bp, ba, bd, bs, ts, tf, td, errs;
        bit  ok;
        bp = q_pix.size(); ba = q_addr.size(); bd = done_cnt; bs = stab_err;
        rand_ready = 1'b1;
        run_a(-1, ts, tf, td, ok);
        rand_ready = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no done expected done"); end
        n_checks++;
        if (q_addr.size() - ba !== 196) begin
            n_fail++; $display("FAIL stall_reads: got %0d expected 196", q_addr.size() - ba);
        end
        errs = 0;
        for (int i = 0; i < 784 && bp + i < q_pix.size(); i++) if (q_pix[bp + i] !== exp_pix(i)) errs++;
        n_checks++;
        if (errs !== 0 || q_pix.size() - bp !== 784) begin
            n_fail++; $display("FAIL stall_pixels: got %0d pixels %0d bad expected 784 0",
                q_pix.size() - bp, errs);
        end
        n_checks++;
        if (stab_err - bs !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d expected 0", stab_err - bs); end
        n_checks++;
        if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL stall_done: got %0d expected 1", done_cnt - bd); end
        $display("test_stall: %0d cycles for 784 pixels", td - ts);
    endtask

    task automatic test_restart_ignored();
        int  bp, ba, bd, ts, tf, td;
        bit  ok;
        bp = q_pix.size(); ba = q_addr.size(); bd = done_cnt;
        run_a(300, ts, tf, td, ok);
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || busy !== 1'b0) begin
            n_fail++; $display("FAIL restart_idle: ok %b busy %b expected 1 0", ok, busy);
        end
        n_checks++;
        if (q_pix.size() - bp !== 784 || q_addr.size() - ba !== 196) begin
            n_fail++; $display("FAIL restart_counts: got %0d pixels %0d reads expected 784 196",
                q_pix.size() - bp, q_addr.size() - ba);
        end
        n_checks++;
        if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL restart_done: got %0d expected 1", done_cnt - bd); end
        n_checks++;
        if (td - ts !== 1177) begin n_fail++; $display("FAIL restart_time: got %0d expected 1177", td - ts); end
        $display("test_restart_ignored: %0d pixels, %0d done", q_pix.size() - bp, done_cnt - bd);
    endtask

    task automatic test_abort();
        int  bp, ba, bd, ts, tf, td, errs;
        bit  ok;
        bp = q_pix.size(); ba = q_addr.size(); bd = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        ts = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        // Pixel 100 is on the bus in cycle start+3+100+2*25.
        for (int i = 0; i < 400 && cyc < ts + 153; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_checks++;
        if ({busy, done, pix_valid, pix_last, ram_chipselect, ram_clken} !== 6'b0 ||
            ram_address !== 10'd0 || pix_data !== 8'd0) begin
            n_fail++; $display("FAIL abort_outputs: ctrl %b addr %0d data %0d expected 0 0 0",
                {busy, done, pix_valid, pix_last, ram_chipselect, ram_clken}, ram_address, pix_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (q_pix.size() - bp !== 100 || q_addr.size() - ba !== 26) begin
            n_fail++; $display("FAIL abort_progress: got %0d pixels %0d reads expected 100 26",
                q_pix.size() - bp, q_addr.size() - ba);
        end
        n_checks++;
        if (done_cnt - bd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt - bd); end
        bp = q_pix.size(); ba = q_addr.size();
        run_a(-1, ts, tf, td, ok);
        n_checks++;
        if (!ok || q_addr.size() <= ba || q_addr[ba] !== 0) begin
            n_fail++; $display("FAIL abort_restart_addr: ok %b first addr %0d expected 1 0",
                ok, (q_addr.size() > ba) ? q_addr[ba] : -1);
        end
        errs = 0;
        for (int i = 0; i < 784 && bp + i < q_pix.size(); i++) if (q_pix[bp + i] !== exp_pix(i)) errs++;
        n_checks++;
        if (errs !== 0 || q_pix.size() - bp !== 784) begin
            n_fail++; $display("FAIL abort_restart_pixels: got %0d pixels %0d bad expected 784 0",
                q_pix.size() - bp, errs);
        end
        $display("test_abort: restart streamed %0d pixels", q_pix.size() - bp);
    endtask

    task automatic test_short_image();
        logic [7:0] exp_s [6];
        int  ts, tf, td, errs;
        exp_s = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd11, 8'd12};
        tf = -1; td = -1;
        @(posedge clk); #1;
        s_start = 1'b1;
        ts = cyc;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (s_valid && tf < 0) tf = cyc;
            if (s_done) begin td = cyc; break; end
        end
        n_checks++;
        if (s_q_addr.size() !== 2 || s_q_addr[0] !== 10 || s_q_addr[1] !== 11) begin
            n_fail++; $display("FAIL short_reads: got %0d reads expected 2 at 10,11", s_q_addr.size());
        end
        errs = 0;
        for (int i = 0; i < 6 && i < s_q_pix.size(); i++) if (s_q_pix[i] !== exp_s[i]) errs++;
        n_checks++;
        if (s_q_pix.size() !== 6 || errs !== 0) begin
            n_fail++; $display("FAIL short_pixels: got %0d pixels %0d bad expected 6 0", s_q_pix.size(), errs);
        end
        n_checks++;
        if (s_last_cnt !== 1 || s_last_pos !== 5) begin
            n_fail++; $display("FAIL short_last: got count %0d pos %0d expected 1 5", s_last_cnt, s_last_pos);
        end
        n_checks++;
        if (s_done_cnt !== 1 || tf - ts !== 3 || td - ts !== 11) begin
            n_fail++; $display("FAIL short_timing: done %0d first %0d end %0d expected 1 3 11",
                s_done_cnt, tf - ts, td - ts);
        end
        $display("test_short_image: %0d pixels, %0d reads", s_q_pix.size(), s_q_addr.size());
    endtask

    task automatic test_protocol();
        n_checks++;
        if (prot_err !== 0 || s_prot_err !== 0) begin
            n_fail++; $display("FAIL ram_protocol: got %0d %0d expected 0 0", prot_err, s_prot_err);
        end
        n_checks++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL pix_stable: got %0d expected 0", stab_err); end
        $display("test_protocol: %0d and %0d violations", prot_err, s_prot_err);
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_short_image();
        test_stall();
        test_restart_ignored();
        test_abort();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
